exception_sequencer: RTL and testbench

- Sits directly downstream of the overflow-detection stage in the multi-cycle MIPS CPU.
- Consumes the overflow flag, faulting PC and destination register that stage produces, plus an external interrupt request.
- Sequences the exception response: suppresses the faulting writeback, drains for a fixed count, then redirects the PC to the handler.
- Holds EPC, cause and the EXL bit, and services ERET.

---
 rtl/exception_sequencer.sv | 148 ++++++++++++++
 tb/tb_exception_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exception_sequencer.sv
// rtl/exception_sequencer.sv - overflow/interrupt/ERET exception sequencer for the multi-cycle MIPS CPU
module exception_sequencer #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0080,
    parameter int          DRAIN_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_flag,
    input  logic        exp_write,
    input  logic [31:0] exc_pc,
    input  logic [4:0]  exc_rd,
    input  logic        irq,
    input  logic        instr_boundary,
    input  logic [31:0] next_pc,
    input  logic        eret,
    output logic        kill_wb,
    output logic        busy,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic [31:0] epc,
    output logic [4:0]  cause,
    output logic [4:0]  bad_rd,
    output logic        exl
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        KILL     = 2'd1,
        DRAIN    = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    localparam logic [4:0] CAUSE_OVF  = 5'd12;
    localparam logic [4:0] CAUSE_INT  = 5'd0;
    // Counter preload so that DRAIN lasts exactly DRAIN_CYCLES cycles.
    localparam logic [3:0] DRAIN_LOAD = (DRAIN_CYCLES > 0) ? 4'(DRAIN_CYCLES - 1) : 4'd0;
    localparam state_t     POST_KILL  = (DRAIN_CYCLES > 0) ? DRAIN : REDIRECT;

    state_t     state;
    state_t     state_nx;
    logic [3:0] drain_cnt;
    logic       ret_eret;

    // Event decode; only meaningful in IDLE, priority overflow > interrupt > ERET.
    logic take_ovf;
    logic take_irq;
    logic take_eret;

    assign take_ovf  = (state == IDLE) && exc_flag && exp_write;
    assign take_irq  = (state == IDLE) && irq && instr_boundary && !exl && !take_ovf;
    assign take_eret = (state == IDLE) && eret && instr_boundary && exl && !take_ovf && !take_irq;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (take_ovf) begin
                    state_nx = KILL;
                end else if (take_irq) begin
                    state_nx = POST_KILL;
                end else if (take_eret) begin
                    state_nx = REDIRECT;
                end
            end
            KILL:     state_nx = POST_KILL;
            DRAIN:    state_nx = (drain_cnt == 4'd0) ? REDIRECT : DRAIN;
            REDIRECT: state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Moore outputs decoded from state.
    always_comb begin
        kill_wb  = 1'b0;
        busy     = 1'b0;
        redirect = 1'b0;
        case (state)
            KILL: begin
                kill_wb = 1'b1;
                busy    = 1'b1;
            end
            DRAIN: begin
                busy = 1'b1;
            end
            REDIRECT: begin
                busy     = 1'b1;
                redirect = 1'b1;
            end
            default: ;
        endcase
    end

    // Drain counter: preload on entry to DRAIN, count down while in it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drain_cnt <= 4'd0;
        end else if ((state_nx == DRAIN) && (state != DRAIN)) begin
            drain_cnt <= DRAIN_LOAD;
        end else if ((state == DRAIN) && (drain_cnt != 4'd0)) begin
            drain_cnt <= drain_cnt - 4'd1;
        end
    end

    // Architectural registers: captured on event entry, exl resolved on redirect exit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            epc         <= 32'd0;
            cause       <= 5'd0;
            bad_rd      <= 5'd0;
            exl         <= 1'b0;
            redirect_pc <= 32'd0;
            ret_eret    <= 1'b0;
        end else begin
            if (take_ovf) begin
                bad_rd      <= exc_rd;
                cause       <= CAUSE_OVF;
                redirect_pc <= HANDLER_ADDR;
                ret_eret    <= 1'b0;
                // A fault inside the handler must not clobber the original return address.
                if (!exl) begin
                    epc <= exc_pc;
                end
            end else if (take_irq) begin
                epc         <= next_pc;
                cause       <= CAUSE_INT;
                redirect_pc <= HANDLER_ADDR;
                ret_eret    <= 1'b0;
            end else if (take_eret) begin
                redirect_pc <= epc;
                ret_eret    <= 1'b1;
            end
            if (state == REDIRECT) begin
                exl <= !ret_eret;
            end
        end
    end

endmodule

// File: tb/tb_exception_sequencer.sv
// tb/tb_exception_sequencer.sv - scoreboard bench for exception_sequencer
module tb_exception_sequencer;

    logic        clk;
    logic        reset;
    logic        exc_flag;
    logic        exp_write;
    logic [31:0] exc_pc;
    logic [4:0]  exc_rd;
    logic        irq;
    logic        instr_boundary;
    logic [31:0] next_pc;
    logic        eret;
    logic        kill_wb;
    logic        busy;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] epc;
    logic [4:0]  cause;
    logic [4:0]  bad_rd;
    logic        exl;

    typedef struct {
        logic [31:0] pc;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    exception_sequencer #(
        .HANDLER_ADDR(32'h0000_0080),
        .DRAIN_CYCLES(1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .exc_flag       (exc_flag),
        .exp_write      (exp_write),
        .exc_pc         (exc_pc),
        .exc_rd         (exc_rd),
        .irq            (irq),
        .instr_boundary (instr_boundary),
        .next_pc        (next_pc),
        .eret           (eret),
        .kill_wb        (kill_wb),
        .busy           (busy),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .epc            (epc),
        .cause          (cause),
        .bad_rd         (bad_rd),
        .exl            (exl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Scoreboard: every redirect pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (redirect === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_redirect: got redirect_pc=%h at cycle %0d, none expected", redirect_pc, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (redirect_pc !== e.pc || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL redirect: got pc=%h cycle=%0d, expected pc=%h cycle=%0d", redirect_pc, cyc, e.pc, e.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        exc_flag       = 1'b0;
        exp_write      = 1'b0;
        exc_pc         = 32'd0;
        exc_rd         = 5'd0;
        irq            = 1'b0;
        instr_boundary = 1'b0;
        next_pc        = 32'd0;
        eret           = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] pc, input int lat);
        exp_t e;
        e.pc  = pc;
        e.cyc = cyc + lat;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({kill_wb, busy, redirect, exl} !== 4'b0 || redirect_pc !== 32'd0 || epc !== 32'd0
            || cause !== 5'd0 || bad_rd !== 5'd0) begin
            failures++;
            $display("FAIL reset_state: got kill=%b busy=%b redir=%b exl=%b rpc=%h epc=%h cause=%0d bad_rd=%0d, expected all 0",
                     kill_wb, busy, redirect, exl, redirect_pc, epc, cause, bad_rd);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_unqualified();
        exc_flag = 1'b1;
        exp_write = 1'b0;
        exc_pc = 32'h1234_0000;
        exc_rd = 5'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({busy, kill_wb, redirect} !== 3'b000 || cause !== 5'd0 || bad_rd !== 5'd0) begin
                failures++;
                $display("FAIL unqualified_flag: got busy=%b kill=%b redir=%b cause=%0d bad_rd=%0d, expected 0",
                         busy, kill_wb, redirect, cause, bad_rd);
            end
        end
        clear_inputs();
    endtask

    task automatic test_eret_ignored();
        eret = 1'b1;
        instr_boundary = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || exl !== 1'b0) begin
                failures++;
                $display("FAIL eret_exl0: got busy=%b exl=%b, expected 0 0", busy, exl);
            end
        end
        clear_inputs();
    endtask

    task automatic test_overflow();
        exc_flag = 1'b1;
        exp_write = 1'b1;
        exc_pc = 32'h0040_0010;
        exc_rd = 5'd9;
        push_exp(32'h0000_0080, 3);
        tick();
        clear_inputs();
        checks++;
        if (kill_wb !== 1'b1 || busy !== 1'b1 || redirect !== 1'b0) begin
            failures++;
            $display("FAIL ovf_kill: got kill=%b busy=%b redir=%b, expected 1 1 0", kill_wb, busy, redirect);
        end
        tick();
        checks++;
        if (kill_wb !== 1'b0 || busy !== 1'b1 || redirect !== 1'b0) begin
            failures++;
            $display("FAIL ovf_drain: got kill=%b busy=%b redir=%b, expected 0 1 0", kill_wb, busy, redirect);
        end
        tick();
        tick();
        checks++;
        if (epc !== 32'h0040_0010 || cause !== 5'd12 || bad_rd !== 5'd9 || exl !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ovf_regs: got epc=%h cause=%0d bad_rd=%0d exl=%b busy=%b, expected 00400010 12 9 1 0",
                     epc, cause, bad_rd, exl, busy);
        end
    endtask

    task automatic test_irq_masked();
        irq = 1'b1;
        instr_boundary = 1'b1;
        next_pc = 32'h0040_0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || epc !== 32'h0040_0010) begin
                failures++;
                $display("FAIL irq_masked: got busy=%b epc=%h, expected 0 00400010", busy, epc);
            end
        end
        clear_inputs();
    endtask

    task automatic test_nested_overflow();
        exc_flag = 1'b1;
        exp_write = 1'b1;
        exc_pc = 32'h0000_0090;
        exc_rd = 5'd17;
        push_exp(32'h0000_0080, 3);
        tick();
        clear_inputs();
        repeat (3) tick();
        checks++;
        if (epc !== 32'h0040_0010 || cause !== 5'd12 || bad_rd !== 5'd17 || exl !== 1'b1) begin
            failures++;
            $display("FAIL nested_ovf: got epc=%h cause=%0d bad_rd=%0d exl=%b, expected 00400010 12 17 1",
                     epc, cause, bad_rd, exl);
        end
    endtask

    task automatic test_eret(input logic [31:0] ret_pc);
        eret = 1'b1;
        instr_boundary = 1'b1;
        push_exp(ret_pc, 1);
        tick();
        clear_inputs();
        tick();
        checks++;
        if (exl !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL eret_exit: got exl=%b busy=%b, expected 0 0", exl, busy);
        end
    endtask

    task automatic test_interrupt();
        irq = 1'b1;
        instr_boundary = 1'b1;
        next_pc = 32'h0040_0024;
        push_exp(32'h0000_0080, 2);
        tick();
        clear_inputs();
        checks++;
        if (busy !== 1'b1 || kill_wb !== 1'b0) begin
            failures++;
            $display("FAIL irq_drain: got busy=%b kill=%b, expected 1 0", busy, kill_wb);
        end
        tick();
        tick();
        checks++;
        if (epc !== 32'h0040_0024 || cause !== 5'd0 || exl !== 1'b1 || bad_rd !== 5'd17) begin
            failures++;
            $display("FAIL irq_regs: got epc=%h cause=%0d exl=%b bad_rd=%0d, expected 00400024 0 1 17",
                     epc, cause, exl, bad_rd);
        end
    endtask

    task automatic test_priority();
        exc_flag = 1'b1;
        exp_write = 1'b1;
        exc_pc = 32'h0040_0200;
        exc_rd = 5'd5;
        irq = 1'b1;
        instr_boundary = 1'b1;
        next_pc = 32'h0040_0300;
        push_exp(32'h0000_0080, 3);
        tick();
        clear_inputs();
        checks++;
        if (kill_wb !== 1'b1) begin
            failures++;
            $display("FAIL prio_kill: got kill=%b, expected 1", kill_wb);
        end
        repeat (3) tick();
        checks++;
        if (cause !== 5'd12 || epc !== 32'h0040_0200 || bad_rd !== 5'd5 || exl !== 1'b1) begin
            failures++;
            $display("FAIL prio_regs: got cause=%0d epc=%h bad_rd=%0d exl=%b, expected 12 00400200 5 1",
                     cause, epc, bad_rd, exl);
        end
    endtask

    task automatic test_reset_in_drain();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        irq = 1'b1;
        instr_boundary = 1'b1;
        next_pc = 32'h0040_0400;
        tick();
        clear_inputs();
        checks++;
        if (busy !== 1'b1 || epc !== 32'h0040_0400) begin
            failures++;
            $display("FAIL drain_entry: got busy=%b epc=%h, expected 1 00400400", busy, epc);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || redirect !== 1'b0 || exl !== 1'b0 || epc !== 32'd0 || redirect_pc !== 32'd0) begin
            failures++;
            $display("FAIL async_reset: got busy=%b redir=%b exl=%b epc=%h rpc=%h, expected all 0",
                     busy, redirect, exl, epc, redirect_pc);
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || redirect !== 1'b0) begin
                failures++;
                $display("FAIL post_reset_idle: got busy=%b redir=%b, expected 0 0", busy, redirect);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_unqualified();
        test_eret_ignored();
        test_overflow();
        test_irq_masked();
        test_nested_overflow();
        test_eret(32'h0040_0010);
        test_interrupt();
        test_eret(32'h0040_0024);
        test_priority();
        test_reset_in_drain();
        repeat (2) tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d redirects still pending, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
